// File: rtl/rtc_seq_ctrl_pkg.sv
// Shared definitions for the RTC register-map sequencer: FSM encoding, burst
// mode, register index map and the index-walk helpers.
package rtc_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_GAP,
    ST_FIN
  } state_t;

  typedef enum logic {
    MODE_RD = 1'b0,
    MODE_WR = 1'b1
  } mode_t;

  // Register index map as seen by the external address decoder.
  localparam logic [3:0] IDX_SEG      = 4'd0;
  localparam logic [3:0] IDX_MIN      = 4'd1;
  localparam logic [3:0] IDX_HORA     = 4'd2;
  localparam logic [3:0] IDX_DIA      = 4'd3;
  localparam logic [3:0] IDX_MES      = 4'd4;
  localparam logic [3:0] IDX_ANIO     = 4'd5;
  localparam logic [3:0] IDX_SEG_TMR  = 4'd6;
  localparam logic [3:0] IDX_MIN_TMR  = 4'd7;
  localparam logic [3:0] IDX_HORA_TMR = 4'd8;
  localparam logic [3:0] IDX_CMD      = 4'd10;

  // Bus address the decoder produces for IDX_CMD.
  localparam logic [7:0] CMD_ADDR = 8'hF0;

  // Read bursts lead with the command access; write bursts trail with it.
  function automatic logic [3:0] advance_idx(
    input mode_t      mode,
    input logic [3:0] idx,
    input logic [3:0] first_idx,
    input logic [3:0] last_idx,
    input logic [3:0] cmd_idx
  );
    if (mode == MODE_RD)
      return (idx == cmd_idx) ? first_idx : idx + 4'd1;
    else
      return (idx == last_idx) ? cmd_idx : idx + 4'd1;
  endfunction

  // The command access is always a write, whatever the burst direction.
  function automatic logic access_is_wr(
    input mode_t      mode,
    input logic [3:0] idx,
    input logic [3:0] cmd_idx
  );
    return (mode == MODE_WR) || (idx == cmd_idx);
  endfunction

endpackage

// File: rtl/rtc_seq_timer.sv
// Loadable down-counter with a zero flag; stops at zero. Shared by the
// inter-access gap and the bus_done timeout.
module rtc_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && (count != '0))
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/rtc_seq_ctrl.sv
// RTC register-map sequencer: walks the register index for the external
// decoder and runs one req/done handshake per register with the bus engine.
module rtc_seq_ctrl
  import rtc_seq_ctrl_pkg::*;
#(
  parameter int FIRST_IDX   = int'(IDX_SEG),
  parameter int LAST_IDX    = int'(IDX_HORA_TMR),
  parameter int CMD_IDX     = int'(IDX_CMD),
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_rd,
  input  logic       start_wr,
  input  logic       bus_done,
  input  logic [7:0] bus_rdata,
  output logic [3:0] dir_idx,
  output logic       dir_en,
  output logic       bus_req,
  output logic       bus_wr,
  output logic       rd_we,
  output logic [3:0] rd_idx,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  localparam logic [3:0] FIRST_I = 4'(FIRST_IDX);
  localparam logic [3:0] LAST_I  = 4'(LAST_IDX);
  localparam logic [3:0] CMD_I   = 4'(CMD_IDX);

  // Loaded one short: the zero-count cycle is itself the last counted cycle.
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

  state_t     state, state_nxt;
  mode_t      mode_q, mode_nxt;
  logic [3:0] dir_idx_nxt, rd_idx_nxt, idx_adv;
  logic [7:0] rd_data_nxt;
  logic       dir_en_nxt, bus_req_nxt, bus_wr_nxt, rd_we_nxt;
  logic       busy_nxt, done_nxt, err_nxt;
  logic       last_acc;

  logic to_load, to_en, to_zero;
  logic gap_load, gap_en, gap_zero;

  rtc_seq_timer #(.W(TO_W)) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .load     (to_load),
    .load_val (TO_LOAD),
    .en       (to_en),
    .zero     (to_zero)
  );

  rtc_seq_timer #(.W(GAP_W)) u_gap (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .en       (gap_en),
    .zero     (gap_zero)
  );

  assign last_acc = (mode_q == MODE_RD) ? (dir_idx == LAST_I) : (dir_idx == CMD_I);
  assign idx_adv  = advance_idx(mode_q, dir_idx, FIRST_I, LAST_I, CMD_I);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      mode_q  <= MODE_RD;
      dir_idx <= '0;
      dir_en  <= 1'b0;
      bus_req <= 1'b0;
      bus_wr  <= 1'b0;
      rd_we   <= 1'b0;
      rd_idx  <= '0;
      rd_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      mode_q  <= mode_nxt;
      dir_idx <= dir_idx_nxt;
      dir_en  <= dir_en_nxt;
      bus_req <= bus_req_nxt;
      bus_wr  <= bus_wr_nxt;
      rd_we   <= rd_we_nxt;
      rd_idx  <= rd_idx_nxt;
      rd_data <= rd_data_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
    end
  end

  // Outputs are computed one cycle ahead so each is a plain flop.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would infer a latch.
    state_nxt   = state;
    mode_nxt    = mode_q;
    dir_idx_nxt = dir_idx;
    dir_en_nxt  = dir_en;
    bus_req_nxt = bus_req;
    bus_wr_nxt  = bus_wr;
    rd_we_nxt   = 1'b0;
    rd_idx_nxt  = rd_idx;
    rd_data_nxt = rd_data;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    to_load     = 1'b0;
    to_en       = 1'b0;
    gap_load    = 1'b0;
    gap_en      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start_wr || start_rd) begin
          mode_nxt    = start_wr ? MODE_WR : MODE_RD;
          dir_idx_nxt = start_wr ? FIRST_I : CMD_I;
          bus_wr_nxt  = access_is_wr(start_wr ? MODE_WR : MODE_RD,
                                     start_wr ? FIRST_I : CMD_I, CMD_I);
          dir_en_nxt  = 1'b1;
          bus_req_nxt = 1'b1;
          busy_nxt    = 1'b1;
          state_nxt   = ST_REQ;
        end
      end

      ST_REQ: begin
        to_load   = 1'b1;
        state_nxt = ST_WAIT;
      end

      ST_WAIT: begin
        // bus_done is checked first so it wins over a same-cycle timeout.
        if (bus_done) begin
          bus_req_nxt = 1'b0;
          dir_en_nxt  = 1'b0;
          bus_wr_nxt  = 1'b0;
          if (!bus_wr) begin
            rd_we_nxt   = 1'b1;
            rd_idx_nxt  = dir_idx;
            rd_data_nxt = bus_rdata;
          end
          if (last_acc) begin
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = ST_FIN;
          end else begin
            gap_load  = 1'b1;
            state_nxt = ST_GAP;
          end
        end else if (to_zero) begin
          bus_req_nxt = 1'b0;
          dir_en_nxt  = 1'b0;
          bus_wr_nxt  = 1'b0;
          err_nxt     = 1'b1;
          busy_nxt    = 1'b0;
          state_nxt   = ST_IDLE;
        end else begin
          to_en = 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_zero) begin
          dir_idx_nxt = idx_adv;
          bus_wr_nxt  = access_is_wr(mode_q, idx_adv, CMD_I);
          dir_en_nxt  = 1'b1;
          bus_req_nxt = 1'b1;
          state_nxt   = ST_REQ;
        end else begin
          gap_en = 1'b1;
        end
      end

      ST_FIN: state_nxt = ST_IDLE;

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rtc_seq_ctrl.sv
// Scoreboard bench for rtc_seq_ctrl: a behavioural bus engine answers each
// request, expected accesses and captured bytes are queued and compared.
module tb_rtc_seq_ctrl;

  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_rd = 1'b0;
  logic       start_wr = 1'b0;
  logic       bus_done = 1'b0;
  logic [7:0] bus_rdata = 8'h00;
  logic [3:0] dir_idx, rd_idx;
  logic [7:0] rd_data;
  logic       dir_en, bus_req, bus_wr, rd_we, busy, done, err;

  rtc_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start_rd  (start_rd),
    .start_wr  (start_wr),
    .bus_done  (bus_done),
    .bus_rdata (bus_rdata),
    .dir_idx   (dir_idx),
    .dir_en    (dir_en),
    .bus_req   (bus_req),
    .bus_wr    (bus_wr),
    .rd_we     (rd_we),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [3:0] idx;
    logic       wr;
  } acc_t;

  typedef struct {
    logic [3:0] idx;
    logic [7:0] data;
  } rd_t;

  acc_t acc_q[$];
  rd_t  rd_q[$];
  acc_t a;
  rd_t  e;

  bit         req_prev = 1'b0;
  int         age = 0, acc_num = 0, gap_cnt = 0, req_len = 0, special_len = 0;
  int         done_cnt = 0, err_cnt = 0, rdwe_cnt = 0;
  int         lat = 3, special_acc = 0, special_lat = 0, lsel = 0;
  logic [3:0] cur_idx = 4'd0;
  logic       cur_wr = 1'b1;

  // Monitor plus bus engine, both sampled away from the rising edge.
  always @(negedge clk) begin
    bus_done = 1'b0;
    if (rd_we) begin
      rdwe_cnt++;
      if (rd_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
      else begin
        e = rd_q.pop_front();
        check("rd_idx", 32'(rd_idx), 32'(e.idx));
        check("rd_data", 32'(rd_data), 32'(e.data));
      end
    end
    if (done) done_cnt++;
    if (err) begin
      err_cnt++;
      check("err_req_low", 32'(bus_req), 32'd0);
      check("err_busy_low", 32'(busy), 32'd0);
    end
    if (bus_req && !req_prev) begin
      acc_num++;
      age = 0;
      req_len = 1;
      if (acc_num > 1) check("gap_len", gap_cnt, GAP);
      gap_cnt = 0;
      if (acc_q.size() == 0) begin
        check("acc_unexpected", 32'd1, 32'd0);
        cur_idx = 4'd0;
        cur_wr = 1'b1;
      end else begin
        a = acc_q.pop_front();
        cur_idx = a.idx;
        cur_wr = a.wr;
        check("acc_idx", 32'(dir_idx), 32'(a.idx));
        check("acc_wr", 32'(bus_wr), 32'(a.wr));
        check("acc_en", 32'(dir_en), 32'd1);
      end
    end else if (bus_req) begin
      age++;
      req_len++;
    end else if (busy) begin
      gap_cnt++;
    end
    if (!bus_req && req_prev && acc_num == special_acc) special_len = req_len;
    req_prev = bus_req;

    if (bus_req) begin
      lsel = (acc_num == special_acc) ? special_lat : lat;
      if (age == lsel) begin
        bus_done = 1'b1;
        bus_rdata = 8'($urandom_range(0, 255));
        if (!cur_wr) rd_q.push_back('{cur_idx, bus_rdata});
      end
    end
  end

  task automatic push_burst(input bit wr);
    if (wr) begin
      for (int i = 0; i <= 8; i++) acc_q.push_back('{4'(i), 1'b1});
      acc_q.push_back('{4'd10, 1'b1});
    end else begin
      acc_q.push_back('{4'd10, 1'b1});
      for (int i = 0; i <= 8; i++) acc_q.push_back('{4'(i), 1'b0});
    end
  endtask

  task automatic start_burst(input bit rd, input bit wr);
    @(negedge clk);
    acc_num = 0;
    gap_cnt = 0;
    start_rd = rd;
    start_wr = wr;
    @(negedge clk);
    start_rd = 1'b0;
    start_wr = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_bounded"}, 32'(n < budget), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_dir_idx"}, 32'(dir_idx), 32'd0);
    check({tag, "_dir_en"}, 32'(dir_en), 32'd0);
    check({tag, "_bus_req"}, 32'(bus_req), 32'd0);
    check({tag, "_bus_wr"}, 32'(bus_wr), 32'd0);
    check({tag, "_rd_we"}, 32'(rd_we), 32'd0);
    check({tag, "_rd_idx"}, 32'(rd_idx), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  int d0, e0, r0, n;

  task automatic snap();
    d0 = done_cnt;
    e0 = err_cnt;
    r0 = rdwe_cnt;
  endtask

  task automatic burst_tail(input string tag, input int exp_done, input int exp_err,
                            input int exp_rd, input int exp_acc);
    check({tag, "_done_cnt"}, done_cnt - d0, exp_done);
    check({tag, "_err_cnt"}, err_cnt - e0, exp_err);
    check({tag, "_rd_we_cnt"}, rdwe_cnt - r0, exp_rd);
    check({tag, "_acc_cnt"}, acc_num, exp_acc);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_rd_left"}, rd_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_outs_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Read burst, bus_done three cycles after each request.
    lat = 3;
    snap();
    push_burst(1'b0);
    start_burst(1'b1, 1'b0);
    wait_end("rd", 2000);
    burst_tail("rd", 1, 0, 9, 10);
    check("rd_acc_left", acc_q.size(), 0);

    // Write burst.
    lat = 2;
    snap();
    push_burst(1'b1);
    start_burst(1'b0, 1'b1);
    wait_end("wr", 2000);
    burst_tail("wr", 1, 0, 0, 10);
    check("wr_acc_left", acc_q.size(), 0);

    // Simultaneous starts: write wins.
    lat = 1;
    snap();
    push_burst(1'b1);
    start_burst(1'b1, 1'b1);
    wait_end("both", 2000);
    burst_tail("both", 1, 0, 0, 10);
    check("both_acc_left", acc_q.size(), 0);

    // start_rd during a burst is dropped, not queued.
    lat = 3;
    snap();
    push_burst(1'b0);
    start_burst(1'b1, 1'b0);
    repeat (20) @(negedge clk);
    start_rd = 1'b1;
    @(negedge clk);
    start_rd = 1'b0;
    wait_end("mid", 2000);
    repeat (30) @(negedge clk);
    burst_tail("mid", 1, 0, 9, 10);
    check("mid_acc_left", acc_q.size(), 0);

    // Third access never answered: timeout after 255 wait cycles.
    special_acc = 3;
    special_lat = 100000;
    snap();
    push_burst(1'b0);
    start_burst(1'b1, 1'b0);
    wait_end("to", 2000);
    burst_tail("to", 0, 1, 1, 3);
    check("to_req_len", special_len, 256);
    check("to_acc_left", acc_q.size(), 7);
    acc_q.delete();
    special_acc = 0;

    snap();
    push_burst(1'b0);
    start_burst(1'b1, 1'b0);
    wait_end("after_to", 2000);
    burst_tail("after_to", 1, 0, 9, 10);

    // bus_done landing on the timeout cycle counts as completion.
    special_acc = 2;
    special_lat = 255;
    snap();
    push_burst(1'b0);
    start_burst(1'b1, 1'b0);
    wait_end("tie", 4000);
    burst_tail("tie", 1, 0, 9, 10);
    check("tie_req_len", special_len, 256);
    special_acc = 0;

    // Reset asserted during the wait of the fifth access.
    lat = 6;
    snap();
    push_burst(1'b0);
    start_burst(1'b1, 1'b0);
    n = 0;
    while (!(acc_num == 5 && bus_req && age >= 2) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_wait", 32'(n < 500), 32'd1);
    #2 reset = 1'b1;
    #1 check_outs_zero("midrst");
    repeat (3) @(negedge clk);
    check("midrst_done_cnt", done_cnt - d0, 0);
    check("midrst_err_cnt", err_cnt - e0, 0);
    acc_q.delete();
    rd_q.delete();
    reset = 1'b0;
    lat = 3;
    snap();
    push_burst(1'b0);
    start_burst(1'b1, 1'b0);
    wait_end("post_rst", 2000);
    burst_tail("post_rst", 1, 0, 9, 10);
    check("post_rst_acc_left", acc_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rtc_seq_ctrl.md
Name: rtc_seq_ctrl

Overview:
- Sequences accesses to the RTC register map.
- Walks the 4-bit register index that feeds the address decoder (index to RTC address), raises its enable, and runs one req/done handshake per register with the bus-cycle engine.
- Read burst: command/transfer access (index 10), then time/timer registers FIRST_IDX..LAST_IDX; each read byte is captured for the display/register file.
- Write burst: the same registers in the same order, then the command access.

Parameters:
- FIRST_IDX, 0, first register index of a burst.
- LAST_IDX, 8, last register index of a burst (hora_timer); must be ≥ FIRST_IDX.
- CMD_IDX, 10, index of the transfer-command access (decodes to 8'hF0).
- GAP_CYC, 4, idle cycles between consecutive bus accesses (≥1).
- TIMEOUT_CYC, 255, max cycles waiting for bus_done before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start_rd  in  1  single-cycle pulse: begin read burst.
- start_wr  in  1  single-cycle pulse: begin write burst.
- bus_done  in  1  single-cycle pulse from bus engine: access complete.
- bus_rdata  in  8  read data, valid in the bus_done cycle.
- dir_idx  out  4  register index to the address decoder.
- dir_en  out  1  decoder enable.
- bus_req  out  1  access request, level.
- bus_wr  out  1  1 = write access, 0 = read; valid while bus_req.
- rd_we  out  1  one-cycle strobe: rd_data valid for rd_idx.
- rd_idx  out  4  index of captured byte.
- rd_data  out  8  captured byte.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at successful burst end.
- err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (async, active-high):
  - State IDLE; all outputs 0.
  - dir_idx = 0, rd_idx = 0, rd_data = 0.
  - Counters cleared.
  - Reset mid-burst aborts immediately; no done or err is produced.
- All outputs are registered.
- States: IDLE, REQ, WAIT, GAP, FIN.
- IDLE:
  - start_wr has priority over start_rd when both arrive in the same cycle.
  - On a start, latch mode (rd/wr), load the first index, set busy, go to REQ.
  - Read mode: first index = CMD_IDX, then FIRST_IDX..LAST_IDX.
  - Write mode: first index = FIRST_IDX..LAST_IDX, then CMD_IDX.
  - Starts arriving while busy are ignored (not queued).
- REQ (1 cycle):
  - Drive dir_idx, dir_en = 1, bus_req = 1, bus_wr.
  - bus_wr = 1 for the command access and for every write-mode access; 0 for read-mode register accesses.
  - Go to WAIT.
- WAIT:
  - Hold bus_req, dir_en, dir_idx and bus_wr stable; increment the timeout counter.
  - On bus_done: drop bus_req and dir_en the next cycle.
  - If the access was a read, pulse rd_we that cycle with rd_idx = dir_idx and rd_data = bus_rdata latched.
  - Then go to GAP, or to FIN if this was the last access.
  - If the counter reaches TIMEOUT_CYC without bus_done: drop bus_req and dir_en, pulse err, clear busy, return to IDLE.
  - bus_done in the same cycle as the timeout: done wins.
- GAP:
  - Count GAP_CYC cycles with bus_req = 0 and dir_en = 0.
  - Advance the index: CMD→FIRST in read mode; idx+1 until LAST, then CMD in write mode.
  - Go to REQ.
- FIN (1 cycle): pulse done, clear busy, go to IDLE.
- bus_done outside WAIT is ignored.
- Burst length = (LAST_IDX − FIRST_IDX + 2) accesses; 10 with the defaults.
- Minimum spacing between REQ cycles = 2 + GAP_CYC + bus latency.
- Index arithmetic is 4-bit unsigned; no wrap is possible with legal parameters.
- Counter widths: ⌈log2(TIMEOUT_CYC+1)⌉ and ⌈log2(GAP_CYC+1)⌉.

Decomposition:
- Shared package: state encoding, the index constants, and the command address 8'hF0.
  - Index constants: IDX_SEG = 0 … IDX_HORA_TMR = 8, IDX_CMD = 10.
- One natural sub-module: rtc_seq_timer, a loadable down-counter used for both the gap and timeout counts (load, en, zero flag).
- The address decoder stays external; dir_idx and dir_en connect straight to it.

Test Plan:
- Read burst with bus_done 3 cycles after each req:
  - dir_idx sequence 10,0,1,…,8.
  - bus_wr = 1 only on the first access.
  - Nine rd_we pulses, rd_idx 0..8, each rd_data equal to the bus_rdata returned.
  - done once; busy low afterward.
- Write burst:
  - dir_idx 0..8 then 10, bus_wr = 1 on all ten accesses.
  - No rd_we pulses; done once.
  - Exactly GAP_CYC = 4 cycles with bus_req = 0 between accesses.
- start_rd and start_wr in the same cycle → write burst runs.
- start_rd pulsed mid-burst → ignored; exactly one done.
- Withhold bus_done on the 3rd access:
  - After 255 WAIT cycles, err pulses and bus_req drops.
  - busy = 0; no done.
  - A following start_rd completes normally.
- Assert reset during WAIT of the 5th access:
  - All outputs 0 immediately, with no done or err.
  - After release, a new burst starts from the first index.
- bus_done in the same cycle as the timeout → treated as done; no err.
